bus_grant_scheduler: RTL and testbench

BUS_GRANT_SCHEDULER -- requirements
Module: bus_grant_scheduler

---
 rtl/bus_grant_scheduler.sv | 175 +++++++++++++++++
 tb/tb_bus_grant_scheduler.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_grant_scheduler.sv
// Two-master, three-slave bus arbiter with serial slave-address decode and a tenure watchdog.
// Latency: grant 1 cycle after a sampled request; sel on the edge sampling the 2nd address bit.
// Backpressure: a selected slave's hold freezes the tenure counter; a non-owner waits until IDLE.
//
// Ports:
//   clk, reset                          - single clock, asynchronous active-high reset
//   m1_/m2_request                      - bus request, held for the whole transaction
//   m1_/m2_address, _address_valid      - serial slave address, MSB first, qualified by valid
//   s1_/s2_/s3_hold                     - slave hold; freezes tenure only when that slave is selected
//   m1_/m2_grant, s1_/s2_/s3_sel        - grant and routing selects (decoded from flops only)
//   state                               - IDLE=0, GRANT=1, CONNECT=2, RELEASE=3
//   timeout_err, decode_err             - single-cycle pulses, visible during RELEASE
//   last_owner                          - 0=m1, 1=m2; owner of the most recent tenure
module bus_grant_scheduler #(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m1_request,
  input  logic       m2_request,
  input  logic       m1_address,
  input  logic       m2_address,
  input  logic       m1_address_valid,
  input  logic       m2_address_valid,
  input  logic       s1_hold,
  input  logic       s2_hold,
  input  logic       s3_hold,
  output logic       m1_grant,
  output logic       m2_grant,
  output logic       s1_sel,
  output logic       s2_sel,
  output logic       s3_sel,
  output logic [2:0] state,
  output logic       timeout_err,
  output logic       decode_err,
  output logic       last_owner
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] GRANT   = 3'd1;
  localparam logic [2:0] CONNECT = 3'd2;
  localparam logic [2:0] RELEASE = 3'd3;

  localparam logic [7:0] TENURE_LAST = 8'(TIMEOUT - 1);

  logic [2:0] state_q, state_d;
  logic       owner_q;        // 0=m1, 1=m2
  logic       last_owner_q;
  logic [1:0] slave_q;        // decoded slave code, 1..3
  logic       addr_msb_q;     // first address bit, waiting for its partner
  logic       bit_cnt_q;      // one bit already taken
  logic [7:0] tenure_q;
  logic       timeout_err_q;
  logic       decode_err_q;

  logic       own_req, own_av, own_bit;
  logic       sel_hold, frozen, tenure_hit;
  logic [1:0] code;
  logic       arb_owner;
  logic       take_bit, set_timeout, set_decode;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    own_req  = owner_q ? m2_request       : m1_request;
    own_av   = owner_q ? m2_address_valid : m1_address_valid;
    own_bit  = owner_q ? m2_address       : m1_address;
    case (slave_q)
      2'd1:    sel_hold = s1_hold;
      2'd2:    sel_hold = s2_hold;
      2'd3:    sel_hold = s3_hold;
      default: sel_hold = 1'b0;
    endcase
    // Only the slave we are routed to may stall the watchdog.
    frozen     = (state_q == CONNECT) && sel_hold;
    tenure_hit = !frozen && (tenure_q == TENURE_LAST);
    code       = {addr_msb_q, own_bit};
    // On a tie the master that did not own the bus last time wins.
    arb_owner  = (m1_request && m2_request) ? ~last_owner_q : m2_request;

    state_d     = state_q;
    take_bit    = 1'b0;
    set_timeout = 1'b0;
    set_decode  = 1'b0;
    case (state_q)
      IDLE: begin
        if (m1_request || m2_request) state_d = GRANT;
      end
      GRANT: begin
        // A dropped request wins over timeout and decode on the same edge.
        if (!own_req) begin
          state_d = RELEASE;
        end else if (tenure_hit) begin
          state_d     = RELEASE;
          set_timeout = 1'b1;
        end else if (own_av) begin
          take_bit = 1'b1;
          if (bit_cnt_q) begin
            if (code == 2'b00) begin
              state_d    = RELEASE;
              set_decode = 1'b1;
            end else begin
              state_d = CONNECT;
            end
          end
        end
      end
      CONNECT: begin
        if (!own_req) begin
          state_d = RELEASE;
        end else if (tenure_hit) begin
          state_d     = RELEASE;
          set_timeout = 1'b1;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: owner, address shifter, tenure counter, error pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q       <= 1'b0;
      last_owner_q  <= 1'b1;
      slave_q       <= 2'd0;
      addr_msb_q    <= 1'b0;
      bit_cnt_q     <= 1'b0;
      tenure_q      <= 8'd0;
      timeout_err_q <= 1'b0;
      decode_err_q  <= 1'b0;
    end else begin
      timeout_err_q <= set_timeout;
      decode_err_q  <= set_decode;
      case (state_q)
        IDLE: begin
          owner_q    <= arb_owner;
          slave_q    <= 2'd0;
          addr_msb_q <= 1'b0;
          bit_cnt_q  <= 1'b0;
          tenure_q   <= 8'd0;
        end
        GRANT, CONNECT: begin
          if (!frozen) tenure_q <= tenure_q + 8'd1;
          if (take_bit) begin
            addr_msb_q <= own_bit;
            bit_cnt_q  <= 1'b1;
          end
          if (state_q == GRANT && state_d == CONNECT) slave_q <= code;
          if (state_d == RELEASE) last_owner_q <= owner_q;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode directly from flops, so reset clears them without a clock edge.
  always_comb begin
    state       = state_q;
    m1_grant    = (state_q == GRANT || state_q == CONNECT) && !owner_q;
    m2_grant    = (state_q == GRANT || state_q == CONNECT) &&  owner_q;
    s1_sel      = (state_q == CONNECT) && (slave_q == 2'd1);
    s2_sel      = (state_q == CONNECT) && (slave_q == 2'd2);
    s3_sel      = (state_q == CONNECT) && (slave_q == 2'd3);
    timeout_err = timeout_err_q;
    decode_err  = decode_err_q;
    last_owner  = last_owner_q;
  end

endmodule

// File: tb/tb_bus_grant_scheduler.sv
module tb_bus_grant_scheduler;

  localparam int TMO  = 255;
  localparam int MAXK = 1024;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       m1_request = 0, m2_request = 0;
  logic       m1_address = 0, m2_address = 0;
  logic       m1_address_valid = 0, m2_address_valid = 0;
  logic       s1_hold = 0, s2_hold = 0, s3_hold = 0;
  logic       m1_grant, m2_grant, s1_sel, s2_sel, s3_sel;
  logic [2:0] state;
  logic       timeout_err, decode_err, last_owner;

  int tests_run = 0;
  int tests_failed = 0;
  logic model_last = 1'b1;

  // Per-edge stimulus: o* = owner's inputs, x* = the other master's inputs.
  // s_hold bit 0 = s1, bit 1 = s2, bit 2 = s3.
  logic       s_oreq[MAXK], s_oav[MAXK], s_oab[MAXK];
  logic       s_xreq[MAXK], s_xav[MAXK], s_xab[MAXK];
  logic [2:0] s_hold[MAXK];

  always #5 clk = ~clk;

  bus_grant_scheduler #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .m1_request(m1_request), .m2_request(m2_request),
    .m1_address(m1_address), .m2_address(m2_address),
    .m1_address_valid(m1_address_valid), .m2_address_valid(m2_address_valid),
    .s1_hold(s1_hold), .s2_hold(s2_hold), .s3_hold(s3_hold),
    .m1_grant(m1_grant), .m2_grant(m2_grant),
    .s1_sel(s1_sel), .s2_sel(s2_sel), .s3_sel(s3_sel),
    .state(state), .timeout_err(timeout_err), .decode_err(decode_err),
    .last_owner(last_owner)
  );

  // Observed output bundle: {state, m1_grant, m2_grant, s1_sel, s2_sel, s3_sel, terr, derr, last_owner}
  function automatic logic [10:0] obs();
    return {state, m1_grant, m2_grant, s1_sel, s2_sel, s3_sel, timeout_err, decode_err, last_owner};
  endfunction

  function automatic logic [10:0] ev(input logic [2:0] st, input logic g1, input logic g2,
                                     input logic [2:0] sel, input logic te, input logic de,
                                     input logic lo);
    return {st, g1, g2, sel, te, de, lo};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    #12;
    tests_run++;
    if (obs() !== ev(3'd0, 0, 0, 3'b000, 0, 0, 1))
      $display("FAIL reset_hold: got %b want %b", obs(), ev(3'd0, 0, 0, 3'b000, 0, 0, 1));
    if (obs() !== ev(3'd0, 0, 0, 3'b000, 0, 0, 1)) tests_failed++;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (obs() !== ev(3'd0, 0, 0, 3'b000, 0, 0, 1)) begin
        tests_failed++;
        $display("FAIL reset_idle%0d: got %b want %b", i, obs(), ev(3'd0, 0, 0, 3'b000, 0, 0, 1));
      end
    end
    model_last = 1'b1;
  endtask

  // Both request out of reset: m1 wins, sends 1,0 -> s2; m2 waits and is granted after RELEASE+IDLE.
  task automatic test_handover();
    logic [3:0]  drv[9];   // {m1_req, m2_req, m1_av, m1_ab}
    logic [10:0] exp[9];
    drv = '{4'b1100, 4'b1111, 4'b1110, 4'b1100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    exp = '{ev(1,1,0,3'b000,0,0,1), ev(1,1,0,3'b000,0,0,1), ev(2,1,0,3'b010,0,0,1),
            ev(2,1,0,3'b010,0,0,1), ev(3,0,0,3'b000,0,0,0), ev(0,0,0,3'b000,0,0,0),
            ev(1,0,1,3'b000,0,0,0), ev(3,0,0,3'b000,0,0,1), ev(0,0,0,3'b000,0,0,1)};
    for (int i = 0; i < 9; i++) begin
      {m1_request, m2_request, m1_address_valid, m1_address} = drv[i];
      @(posedge clk); #1;
      tests_run++;
      if (obs() !== exp[i]) begin
        tests_failed++;
        $display("FAIL handover step %0d: got %b want %b", i, obs(), exp[i]);
      end
    end
    model_last = 1'b1;
  endtask

  // Generic transaction: builds a per-edge stimulus plan, predicts the tenure outcome from the
  // rules (drop > timeout > decode), then drives it and checks every cycle.
  task automatic run_txn(input string name, input logic own_in, input logic tie,
                         input logic b0, input logic b1, input int gap0, input int gap1,
                         input int drop_k, input logic [2:0] hmask, input int hs, input int hl,
                         input logic hrand);
    logic        own, conn, frz;
    logic [1:0]  code;
    logic [2:0]  onehot;
    logic [10:0] exp;
    int p1, p2, end_k, kind, t_conn, nf, nbad;
    own  = tie ? ~model_last : own_in;
    p1   = 1 + gap0;
    p2   = p1 + 1 + gap1;
    code = {b0, b1};
    onehot = (code == 2'd1) ? 3'b100 : (code == 2'd2) ? 3'b010 : 3'b001;
    for (int k = 0; k < MAXK; k++) begin
      s_oreq[k] = (k < drop_k);
      s_oav[k]  = (k == p1 || k == p2) ? 1'b1 : (k > p2 ? 1'($urandom) : 1'b0);
      s_oab[k]  = (k == p1) ? b0 : (k == p2) ? b1 : 1'($urandom);
      s_hold[k] = (k >= hs && k < hs + hl) ? (hrand ? (3'($urandom) & hmask) : hmask) : 3'b000;
      s_xreq[k] = (k == 0) ? tie : 1'($urandom);
      s_xav[k]  = 1'($urandom);
      s_xab[k]  = 1'($urandom);
    end
    end_k = -1; kind = 0; nf = 0;
    for (int k = 1; k < MAXK && end_k < 0; k++) begin
      conn = (code != 2'd0) && (k > p2);
      frz  = 1'b0;
      if (conn) frz = s_hold[k][2'(code - 2'd1)];
      if (!s_oreq[k])                   begin end_k = k; kind = 0; end
      else if (!frz && nf == TMO - 1)   begin end_k = k; kind = 1; end
      else if (k == p2 && code == 2'd0) begin end_k = k; kind = 2; end
      if (!frz) nf++;
    end
    if (end_k < 0 || end_k + 3 > MAXK) begin
      tests_run++; tests_failed++;
      $display("FAIL %s: plan has no end within %0d edges (got %0d)", name, MAXK, end_k);
      return;
    end
    t_conn = (code != 2'd0 && p2 < end_k) ? p2 : MAXK;
    for (int k = end_k + 1; k < MAXK; k++) begin
      s_oreq[k] = 1'b0; s_xreq[k] = 1'b0;
    end
    nbad = 0;
    for (int k = 0; k <= end_k + 2; k++) begin
      if (!own) begin
        m1_request = s_oreq[k]; m1_address_valid = s_oav[k]; m1_address = s_oab[k];
        m2_request = s_xreq[k]; m2_address_valid = s_xav[k]; m2_address = s_xab[k];
      end else begin
        m2_request = s_oreq[k]; m2_address_valid = s_oav[k]; m2_address = s_oab[k];
        m1_request = s_xreq[k]; m1_address_valid = s_xav[k]; m1_address = s_xab[k];
      end
      {s3_hold, s2_hold, s1_hold} = s_hold[k];
      @(posedge clk); #1;
      if (k < end_k)
        exp = ev((k >= t_conn) ? 3'd2 : 3'd1, !own, own, (k >= t_conn) ? onehot : 3'b000,
                 0, 0, model_last);
      else if (k == end_k)
        exp = ev(3'd3, 0, 0, 3'b000, kind == 1, kind == 2, own);
      else
        exp = ev(3'd0, 0, 0, 3'b000, 0, 0, own);
      tests_run++;
      if (obs() !== exp) begin
        tests_failed++;
        if (nbad < 4) $display("FAIL %s edge %0d: got %b want %b", name, k, obs(), exp);
        nbad++;
      end
    end
    {s3_hold, s2_hold, s1_hold} = 3'b000;
    model_last = own;
  endtask

  task automatic test_decode_err();
    run_txn("decode_00", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 50, 3'b000, 0, 0, 1'b0);
  endtask

  task automatic test_drop_in_grant();
    run_txn("drop_in_grant", 1'b0, 1'b0, 1'b1, 1'b1, 0, 3, 3, 3'b000, 0, 0, 1'b0);
  endtask

  task automatic test_hold_freeze();
    run_txn("s3_hold_freeze", 1'b1, 1'b0, 1'b1, 1'b1, 0, 0, 2000, 3'b100, 3, 300, 1'b0);
  endtask

  task automatic test_other_hold();
    run_txn("s2_hold_no_freeze", 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 2000, 3'b010, 0, 1000, 1'b0);
  endtask

  task automatic test_drop_at_timeout();
    run_txn("drop_on_timeout_edge", 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, TMO, 3'b000, 0, 0, 1'b0);
  endtask

  // Reset mid-CONNECT must clear grant/sel without a clock edge.
  task automatic test_reset_mid();
    m2_request = 1'b1; m2_address_valid = 1'b0;
    @(posedge clk); #1;
    m2_address_valid = 1'b1; m2_address = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    m2_address_valid = 1'b0;
    tests_run++;
    if (obs() !== ev(3'd2, 0, 1, 3'b001, 0, 0, model_last)) begin
      tests_failed++;
      $display("FAIL reset_mid_setup: got %b want %b", obs(), ev(3'd2, 0, 1, 3'b001, 0, 0, model_last));
    end
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if (obs() !== ev(3'd0, 0, 0, 3'b000, 0, 0, 1)) begin
      tests_failed++;
      $display("FAIL reset_mid_async: got %b want %b", obs(), ev(3'd0, 0, 0, 3'b000, 0, 0, 1));
    end
    m2_request = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (obs() !== ev(3'd0, 0, 0, 3'b000, 0, 0, 1)) begin
        tests_failed++;
        $display("FAIL reset_mid_resume%0d: got %b want %b", i, obs(), ev(3'd0, 0, 0, 3'b000, 0, 0, 1));
      end
    end
    model_last = 1'b1;
  endtask

  task automatic test_random();
    int g0, g1, p2, dk;
    for (int n = 0; n < 30; n++) begin
      g0 = int'($urandom_range(0, 3));
      g1 = int'($urandom_range(0, 3));
      p2 = 2 + g0 + g1;
      if ($urandom_range(0, 3) == 0) dk = int'($urandom_range(1, p2 - 1));
      else                           dk = p2 + 1 + int'($urandom_range(0, 20));
      run_txn("random", 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), g0, g1, dk,
              3'($urandom), 0, MAXK, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_handover();
    test_decode_err();
    test_drop_in_grant();
    test_hold_freeze();
    test_other_hold();
    test_drop_at_timeout();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
